// File: rtl/coproc_instr_decoder.sv
// Instruction decoder: captures the 22-bit word on a start rising edge, filters illegal opcodes, issues one engine command.
// Latency: result updates 4 cycles after the start edge at best (edge, DECODE, ISSUE, WAIT).
// Backpressure: cmd_* held stable while cmd_valid && !cmd_ready; start edges seen while busy are dropped and counted.
module coproc_instr_decoder #(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter logic [15:0] RESULT_RESET   = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [21:0] instr,
  input  logic        start,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic [3:0]  cmd_op,
  output logic [1:0]  cmd_id,
  output logic [2:0]  cmd_row,
  output logic [2:0]  cmd_col,
  output logic [7:0]  cmd_value,
  output logic [1:0]  cmd_mode,
  input  logic        eng_done,
  input  logic [15:0] eng_result,
  output logic [15:0] result,
  output logic        busy,
  output logic        err_opcode,
  output logic        err_timeout,
  output logic [3:0]  drop_count
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DECODE = 2'd1;
  localparam logic [1:0] S_ISSUE  = 2'd2;
  localparam logic [1:0] S_WAIT   = 2'd3;

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [1:0]       state;
  logic [21:0]      instr_q;
  logic [CNT_W-1:0] tmo_cnt;
  logic             start_q;
  logic             start_armed;
  logic             start_evt;
  logic [3:0]       op_q;
  logic             op_legal;

  // start_q alone would report a rising edge right after reset if start was held
  // high through it; start_armed waits until start has been seen low first.
  assign start_evt = start & ~start_q & start_armed;
  assign op_q      = instr_q[3:0];
  assign op_legal  = (op_q != 4'd0) && (op_q <= 4'd11);
  assign busy      = (state != S_IDLE);

  // Start edge detector state.
  always_ff @(posedge clk) begin
    if (rst) begin
      start_q     <= 1'b0;
      start_armed <= 1'b0;
    end else begin
      start_q <= start;
      if (!start) start_armed <= 1'b1;
    end
  end

  // Saturating count of start edges that arrive while a command is in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      drop_count <= 4'd0;
    end else if (start_evt && busy && (drop_count != 4'd15)) begin
      drop_count <= drop_count + 4'd1;
    end
  end

  // Control FSM: capture, decode, handshake with the engine, collect the result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      instr_q     <= 22'd0;
      tmo_cnt     <= '0;
      cmd_valid   <= 1'b0;
      cmd_op      <= 4'd0;
      cmd_id      <= 2'd0;
      cmd_row     <= 3'd0;
      cmd_col     <= 3'd0;
      cmd_value   <= 8'd0;
      cmd_mode    <= 2'd0;
      result      <= RESULT_RESET;
      err_opcode  <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start_evt) begin
            instr_q <= instr;
            state   <= S_DECODE;
          end
        end
        S_DECODE: begin
          if (!op_legal) begin
            err_opcode <= 1'b1;
            state      <= S_IDLE;
          end else begin
            err_opcode  <= 1'b0;
            err_timeout <= 1'b0;
            cmd_op      <= op_q;
            cmd_id      <= instr_q[11:10];
            cmd_row     <= instr_q[9:7];
            cmd_col     <= instr_q[6:4];
            // Scalar multiply carries its operand in the id/row/col bits.
            cmd_value   <= (op_q == 4'b1000) ? instr_q[11:4] : instr_q[19:12];
            cmd_mode    <= instr_q[21:20];
            cmd_valid   <= 1'b1;
            state       <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (cmd_ready) begin
            cmd_valid <= 1'b0;
            tmo_cnt   <= '0;
            state     <= S_WAIT;
          end
        end
        S_WAIT: begin
          // A done on the last allowed cycle still counts as success.
          if (eng_done) begin
            result <= eng_result;
            state  <= S_IDLE;
          end else if (tmo_cnt == CNT_LAST) begin
            err_timeout <= 1'b1;
            state       <= S_IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + CNT_W'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_coproc_instr_decoder.sv
// Bench for coproc_instr_decoder: directed scenarios plus randomized transactions against a field-level model.
// Latency: inputs driven 1 time unit after each rising edge, outputs sampled at the same point.
// Backpressure: cmd_ready delays and eng_done delays are varied per transaction.
module tb_coproc_instr_decoder;

  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [21:0] instr;
  logic        start;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [3:0]  cmd_op;
  logic [1:0]  cmd_id;
  logic [2:0]  cmd_row;
  logic [2:0]  cmd_col;
  logic [7:0]  cmd_value;
  logic [1:0]  cmd_mode;
  logic        eng_done;
  logic [15:0] eng_result;
  logic [15:0] result;
  logic        busy;
  logic        err_opcode;
  logic        err_timeout;
  logic [3:0]  drop_count;

  coproc_instr_decoder #(.TIMEOUT_CYCLES(TMO), .RESULT_RESET(16'h0000)) dut (
    .clk(clk), .rst(rst), .instr(instr), .start(start),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_id(cmd_id), .cmd_row(cmd_row), .cmd_col(cmd_col),
    .cmd_value(cmd_value), .cmd_mode(cmd_mode),
    .eng_done(eng_done), .eng_result(eng_result),
    .result(result), .busy(busy), .err_opcode(err_opcode),
    .err_timeout(err_timeout), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Observations from the last transaction.
  int          obs_valid_cycles;
  int          obs_wait_len;
  int          obs_total;
  logic        obs_stable;
  logic [21:0] obs_fields;

  // Reference model state.
  logic        e_legal;
  logic [21:0] e_fields;
  logic [15:0] m_result;
  logic        m_err_op;
  logic        m_err_to;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic logic [21:0] cur_fields();
    return {cmd_op, cmd_id, cmd_row, cmd_col, cmd_value, cmd_mode};
  endfunction

  // Expected command derived from the instruction word with plain arithmetic.
  task automatic model_cmd(input logic [21:0] ins);
    int unsigned w, op, col, row, id, val, mode;
    w    = ins;
    op   = w % 16;
    col  = (w / 16) % 8;
    row  = (w / 128) % 8;
    id   = (w / 1024) % 4;
    val  = (op == 8) ? (w / 16) % 256 : (w / 4096) % 256;
    mode = w / 1048576;
    e_legal  = (op >= 1) && (op <= 11);
    e_fields = {4'(op), 2'(id), 3'(row), 3'(col), 8'(val), 2'(mode)};
  endtask

  task automatic model_commit(input logic [21:0] ins, input int done_dly, input logic [15:0] res);
    model_cmd(ins);
    if (!e_legal) begin
      m_err_op = 1'b1;
    end else begin
      m_err_op = 1'b0;
      m_err_to = (done_dly >= TMO);
      if (done_dly < TMO) m_result = res;
    end
  endtask

  // Drives one instruction from IDLE back to IDLE and records what was seen.
  task automatic run_txn(input logic [21:0] ins, input int rdy_dly, input int done_dly, input logic [15:0] res);
    int n;
    int t0;
    obs_valid_cycles = 0;
    obs_stable = 1'b1;
    t0 = cyc;
    instr = ins;
    start = 1'b1;
    tick();
    start = 1'b0;
    instr = 22'($urandom);
    if (cmd_valid) obs_valid_cycles++;
    tick();
    obs_fields = cur_fields();
    n = 0;
    while (cmd_valid && n < 50) begin
      obs_valid_cycles++;
      if (cur_fields() !== obs_fields) obs_stable = 1'b0;
      cmd_ready = (n >= rdy_dly);
      eng_done = 1'($urandom_range(0, 1));
      eng_result = 16'($urandom);
      tick();
      n++;
    end
    cmd_ready = 1'b0;
    n = 0;
    while (busy && n < 200) begin
      eng_done = (n == done_dly);
      eng_result = (n == done_dly) ? res : 16'($urandom);
      tick();
      n++;
    end
    eng_done = 1'b0;
    obs_wait_len = n;
    obs_total = cyc - t0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; instr = 22'd0; cmd_ready = 1'b0; eng_done = 1'b0; eng_result = 16'd0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    checks++;
    if ({cmd_valid, cur_fields()} !== 23'd0) begin
      failures++; $display("FAIL reset_cmd got=%h exp=0", {cmd_valid, cur_fields()});
    end
    checks++;
    if ({result, busy, err_opcode, err_timeout, drop_count} !== 23'd0) begin
      failures++; $display("FAIL reset_status got=%h exp=0", {result, busy, err_opcode, err_timeout, drop_count});
    end
    repeat (3) tick();
    checks++;
    if (busy !== 1'b0 || cmd_valid !== 1'b0) begin
      failures++; $display("FAIL reset_held_start busy=%b valid=%b exp=0", busy, cmd_valid);
    end
    start = 1'b0; tick();
    start = 1'b1; tick();
    checks++;
    if (busy !== 1'b1) begin
      failures++; $display("FAIL reset_new_edge busy=%b exp=1", busy);
    end
    start = 1'b0; tick();
    model_commit(22'd0, 0, 16'd0);
    checks++;
    if (busy !== 1'b0 || err_opcode !== m_err_op) begin
      failures++; $display("FAIL reset_op0 busy=%b err_opcode=%b exp 0/%b", busy, err_opcode, m_err_op);
    end
  endtask

  task automatic test_write();
    logic [21:0] ins;
    ins = 22'b10_00000001_00_000_000_0010;
    run_txn(ins, 0, 3, 16'h0001);
    model_commit(ins, 3, 16'h0001);
    checks++;
    if (obs_fields !== {4'b0010, 2'd0, 3'd0, 3'd0, 8'h01, 2'd2}) begin
      failures++; $display("FAIL write_fields got=%h exp=%h", obs_fields, {4'b0010, 2'd0, 3'd0, 3'd0, 8'h01, 2'd2});
    end
    checks++;
    if (obs_valid_cycles != 1) begin
      failures++; $display("FAIL write_valid_cycles got=%0d exp=1", obs_valid_cycles);
    end
    checks++;
    if (result !== 16'h0001 || busy !== 1'b0 || err_opcode !== 1'b0) begin
      failures++; $display("FAIL write_status result=%h busy=%b err_op=%b exp 0001/0/0", result, busy, err_opcode);
    end
  endtask

  task automatic test_latency();
    logic [21:0] ins;
    ins = 22'h2A5C3;
    run_txn(ins, 0, 0, 16'hBEEF);
    model_commit(ins, 0, 16'hBEEF);
    checks++;
    if (obs_total != 4 || result !== 16'hBEEF) begin
      failures++; $display("FAIL latency cycles=%0d result=%h exp 4/beef", obs_total, result);
    end
  endtask

  task automatic test_scalar();
    logic [21:0] ins;
    ins = 22'b000000000000000101_1000;
    run_txn(ins, 5, 1, 16'h0A0A);
    model_commit(ins, 1, 16'h0A0A);
    checks++;
    if (obs_valid_cycles != 6 || obs_stable !== 1'b1) begin
      failures++; $display("FAIL scalar_hold valid_cycles=%0d stable=%b exp 6/1", obs_valid_cycles, obs_stable);
    end
    checks++;
    if (obs_fields[21:18] !== 4'b1000 || obs_fields[9:2] !== 8'h05) begin
      failures++; $display("FAIL scalar_fields op=%b value=%h exp 1000/05", obs_fields[21:18], obs_fields[9:2]);
    end
    checks++;
    if (result !== 16'h0A0A) begin
      failures++; $display("FAIL scalar_result got=%h exp=0a0a", result);
    end
  endtask

  task automatic test_illegal();
    logic [21:0] ins;
    logic [15:0] prev;
    prev = m_result;
    ins = {2'd1, 8'h33, 2'd1, 3'd2, 3'd3, 4'hF};
    run_txn(ins, 0, 0, 16'hDEAD);
    model_commit(ins, 0, 16'hDEAD);
    checks++;
    if (obs_valid_cycles != 0 || err_opcode !== 1'b1 || result !== prev) begin
      failures++; $display("FAIL illegal valid_cycles=%0d err_op=%b result=%h exp 0/1/%h", obs_valid_cycles, err_opcode, result, prev);
    end
    ins = {2'd3, 8'h7E, 2'd2, 3'd6, 3'd1, 4'b1001};
    run_txn(ins, 1, 2, 16'h4321);
    model_commit(ins, 2, 16'h4321);
    checks++;
    if (err_opcode !== 1'b0 || obs_valid_cycles != 2 || result !== 16'h4321) begin
      failures++; $display("FAIL illegal_recover err_op=%b valid_cycles=%0d result=%h exp 0/2/4321", err_opcode, obs_valid_cycles, result);
    end
  endtask

  task automatic test_timeout();
    logic [21:0] ins;
    logic [15:0] prev;
    prev = m_result;
    ins = {2'd0, 8'h11, 2'd1, 3'd0, 3'd0, 4'b1011};
    run_txn(ins, 0, 1000, 16'h1234);
    model_commit(ins, 1000, 16'h1234);
    checks++;
    if (obs_wait_len != TMO || err_timeout !== 1'b1 || result !== prev) begin
      failures++; $display("FAIL timeout wait=%0d err_to=%b result=%h exp %0d/1/%h", obs_wait_len, err_timeout, result, TMO, prev);
    end
    run_txn(ins, 0, TMO - 1, 16'h5A5A);
    model_commit(ins, TMO - 1, 16'h5A5A);
    checks++;
    if (obs_wait_len != TMO || err_timeout !== 1'b0 || result !== 16'h5A5A) begin
      failures++; $display("FAIL timeout_last_done wait=%0d err_to=%b result=%h exp %0d/0/5a5a", obs_wait_len, err_timeout, result, TMO);
    end
  endtask

  task automatic test_random();
    logic [21:0] ins;
    logic [15:0] res;
    int rd, dd, exp_vc, exp_wl;
    for (int i = 0; i < 40; i++) begin
      ins = 22'($urandom);
      res = 16'($urandom);
      rd = $urandom_range(0, 4);
      dd = $urandom_range(0, TMO + 2);
      run_txn(ins, rd, dd, res);
      model_commit(ins, dd, res);
      exp_vc = e_legal ? rd + 1 : 0;
      exp_wl = !e_legal ? 0 : (dd < TMO) ? dd + 1 : TMO;
      checks++;
      if (obs_valid_cycles != exp_vc || obs_wait_len != exp_wl) begin
        failures++; $display("FAIL rand[%0d] timing valid=%0d wait=%0d exp %0d/%0d", i, obs_valid_cycles, obs_wait_len, exp_vc, exp_wl);
      end
      if (e_legal) begin
        checks++;
        if (obs_fields !== e_fields || obs_stable !== 1'b1) begin
          failures++; $display("FAIL rand[%0d] fields got=%h stable=%b exp=%h", i, obs_fields, obs_stable, e_fields);
        end
      end
      checks++;
      if (result !== m_result || err_opcode !== m_err_op || err_timeout !== m_err_to || busy !== 1'b0) begin
        failures++; $display("FAIL rand[%0d] status result=%h eo=%b et=%b busy=%b exp %h/%b/%b/0", i, result, err_opcode, err_timeout, busy, m_result, m_err_op, m_err_to);
      end
    end
  endtask

  task automatic test_drops();
    int m_drops;
    m_drops = 0;
    instr = {2'd1, 8'hAA, 2'd3, 3'd5, 3'd2, 4'd4};
    start = 1'b1; tick();
    start = 1'b0; tick();
    for (int i = 0; i < 20; i++) begin
      start = 1'b1; tick();
      start = 1'b0; tick();
      m_drops = (m_drops < 15) ? m_drops + 1 : 15;
      if (i == 4 || i == 19) begin
        checks++;
        if (drop_count !== 4'(m_drops)) begin
          failures++; $display("FAIL drops[%0d] got=%0d exp=%0d", i, drop_count, m_drops);
        end
      end
    end
    checks++;
    if (cmd_valid !== 1'b1) begin
      failures++; $display("FAIL drops_still_issue valid=%b exp=1", cmd_valid);
    end
    rst = 1'b1; tick();
    rst = 1'b0;
    m_result = 16'h0000; m_err_op = 1'b0; m_err_to = 1'b0;
    checks++;
    if (cmd_valid !== 1'b0 || busy !== 1'b0 || drop_count !== 4'd0 || cur_fields() !== 22'd0 || result !== m_result) begin
      failures++; $display("FAIL midop_reset valid=%b busy=%b drops=%0d fields=%h result=%h exp all 0", cmd_valid, busy, drop_count, cur_fields(), result);
    end
  endtask

  initial begin
    m_result = 16'h0000; m_err_op = 1'b0; m_err_to = 1'b0;
    test_reset();
    test_write();
    test_latency();
    test_scalar();
    test_illegal();
    test_timeout();
    test_random();
    test_drops();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1);
  end

endmodule
